// File: rtl/reg_write_ctrl.sv
// Register-file write controller: merges pipeline writebacks with queued long-latency results.
// Tracks outstanding writes per register. Optional REG_WRITE_CTRL_FWD_EN adds a write-forwarding port.
module reg_write_ctrl #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  input  logic        wb_r15_we,
  input  logic [15:0] wb_r15_data,
  input  logic        lo_valid,
  output logic        lo_ready,
  input  logic [3:0]  lo_addr,
  input  logic [15:0] lo_data,
  input  logic        lo_r15,
  input  logic [15:0] lo_r15_data,
  input  logic        issue_valid,
  input  logic [3:0]  issue_addr,
  input  logic        issue_r15,
  output logic [3:0]  rf_w_addr,
  output logic [15:0] rf_w_data,
  output logic        rf_reg_we,
  output logic [15:0] rf_w_r15,
  output logic        rf_r15_we,
  output logic [15:0] busy_mask,
  output logic        sb_err
`ifdef REG_WRITE_CTRL_FWD_EN
  ,
  input  logic [3:0]  fwd_addr,
  output logic        fwd_hit,
  output logic [15:0] fwd_data
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] P1    = 1;
  localparam logic [AW:0]   C1    = 1;
  localparam logic [AW:0]   FULLC = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] K1    = 1;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
    logic        r15;
    logic [15:0] r15_data;
  } lo_ent_t;

  lo_ent_t       mem [DEPTH];
  lo_ent_t       head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          drain;

  assign head  = mem[rd_ptr];
  assign full  = (count == FULLC);
  assign empty = (count == '0);
  assign lo_ready = rst && !full;
  assign push  = lo_valid && lo_ready;
  // The pipeline never stalls, so the head only takes ports it leaves idle.
  assign drain = rst && !empty && !wb_we
              && !(head.r15 && wb_r15_we)
              && !(wb_r15_we && head.addr == 4'd15);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{lo_addr, lo_data, lo_r15, lo_r15_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + P1;
      if (drain)
        rd_ptr <= rd_ptr + P1;
      if (push && !drain)
        count <= count + C1;
      else if (drain && !push)
        count <= count - C1;
    end
  end

  logic [15:0]   inc;
  logic [15:0]   dec;
  logic [CW-1:0] cnt [16];

  always_comb begin
    inc = '0;
    dec = '0;
    if (issue_valid) begin
      inc[issue_addr] = 1'b1;
      if (issue_r15 && issue_addr != 4'd15)
        inc[15] = 1'b1;
    end
    if (drain) begin
      dec[head.addr] = 1'b1;
      if (head.r15 && head.addr != 4'd15)
        dec[15] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++)
        cnt[i] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (inc[i] && !dec[i]) begin
          if (cnt[i] == '1)
            sb_err <= 1'b1;
          else
            cnt[i] <= cnt[i] + K1;
        end else if (dec[i] && !inc[i]) begin
          if (cnt[i] == '0)
            sb_err <= 1'b1;
          else
            cnt[i] <= cnt[i] - K1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++)
      busy_mask[i] = (cnt[i] != '0);
  end

  always_comb begin
    rf_w_addr = '0;
    rf_w_data = '0;
    rf_reg_we = 1'b0;
    rf_w_r15  = '0;
    rf_r15_we = 1'b0;
    if (rst) begin
      if (drain) begin
        rf_reg_we = 1'b1;
        rf_w_addr = head.addr;
        rf_w_data = head.data;
      end else if (wb_we) begin
        rf_reg_we = 1'b1;
        rf_w_addr = wb_addr;
        rf_w_data = wb_data;
      end
      if (drain && head.r15) begin
        rf_r15_we = 1'b1;
        rf_w_r15  = head.r15_data;
      end else if (wb_r15_we) begin
        rf_r15_we = 1'b1;
        rf_w_r15  = wb_r15_data;
      end
    end
  end

`ifdef REG_WRITE_CTRL_FWD_EN
  // R15 port wins, matching register-file write order.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (rf_r15_we && fwd_addr == 4'd15) begin
      fwd_hit  = 1'b1;
      fwd_data = rf_w_r15;
    end else if (rf_reg_we && rf_w_addr == fwd_addr) begin
      fwd_hit  = 1'b1;
      fwd_data = rf_w_data;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Testbench for reg_write_ctrl: scoreboard of queued long-latency writes.
// Expected drains are pushed on acceptance and popped when the DUT writes.
module tb_reg_write_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        wb_r15_we;
  logic [15:0] wb_r15_data;
  logic        lo_valid;
  logic        lo_ready;
  logic [3:0]  lo_addr;
  logic [15:0] lo_data;
  logic        lo_r15;
  logic [15:0] lo_r15_data;
  logic        issue_valid;
  logic [3:0]  issue_addr;
  logic        issue_r15;
  logic [3:0]  rf_w_addr;
  logic [15:0] rf_w_data;
  logic        rf_reg_we;
  logic [15:0] rf_w_r15;
  logic        rf_r15_we;
  logic [15:0] busy_mask;
  logic        sb_err;
`ifdef REG_WRITE_CTRL_FWD_EN
  logic [3:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
`endif

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic        r15;
    logic [15:0] r15_data;
  } exp_t;

  exp_t sbq [$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   mcount = 0;

  always #5 clk = ~clk;

  reg_write_ctrl #(.DEPTH(DEPTH), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_r15_we(wb_r15_we), .wb_r15_data(wb_r15_data),
    .lo_valid(lo_valid), .lo_ready(lo_ready),
    .lo_addr(lo_addr), .lo_data(lo_data),
    .lo_r15(lo_r15), .lo_r15_data(lo_r15_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .issue_r15(issue_r15),
    .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .rf_reg_we(rf_reg_we), .rf_w_r15(rf_w_r15),
    .rf_r15_we(rf_r15_we), .busy_mask(busy_mask),
    .sb_err(sb_err)
`ifdef REG_WRITE_CTRL_FWD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  // Pop an expected entry whenever the queue side owns the general port.
  always begin
    @(negedge clk);
    #2;
    if (rf_reg_we && !wb_we) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL drain_unexpected addr=%0d data=%h required=no_write",
                 rf_w_addr, rf_w_data);
      end else begin
        mon_e = sbq.pop_front();
        mcount--;
        if (rf_w_addr !== mon_e.addr || rf_w_data !== mon_e.data
            || (!wb_r15_we && rf_r15_we !== mon_e.r15)
            || (mon_e.r15 && rf_w_r15 !== mon_e.r15_data)) begin
          failures++;
          $display("FAIL drain_order got=%0d/%h/%b/%h required=%0d/%h/%b/%h",
                   rf_w_addr, rf_w_data, rf_r15_we, rf_w_r15,
                   mon_e.addr, mon_e.data, mon_e.r15, mon_e.r15_data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    wb_we = 0; wb_addr = 0; wb_data = 0;
    wb_r15_we = 0; wb_r15_data = 0;
    lo_valid = 0; lo_addr = 0; lo_data = 0;
    lo_r15 = 0; lo_r15_data = 0;
    issue_valid = 0; issue_addr = 0; issue_r15 = 0;
`ifdef REG_WRITE_CTRL_FWD_EN
    fwd_addr = 0;
`endif
  endtask

  // Drive one offer this cycle; record it if the model says it is accepted.
  task automatic send_lo(input logic [3:0] a, input logic [15:0] d,
                         input logic r, input logic [15:0] rd);
    lo_valid = 1; lo_addr = a; lo_data = d;
    lo_r15 = r; lo_r15_data = rd;
    if (mcount < DEPTH) begin
      sbq.push_back('{a, d, r, rd});
      mcount++;
    end
  endtask

  task automatic test_reset();
    rst = 0;
    idle();
    wb_we = 1; wb_addr = 4; wb_data = 16'hBEEF; lo_valid = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (lo_ready !== 1'b0) begin
      failures++; $display("FAIL rst_ready got=%b required=0", lo_ready);
    end
    checks++;
    if (rf_reg_we !== 1'b0 || rf_r15_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_we got=%b/%b required=0/0", rf_reg_we, rf_r15_we);
    end
    checks++;
    if (rf_w_addr !== 4'd0 || rf_w_data !== 16'd0) begin
      failures++;
      $display("FAIL rst_data got=%0d/%h required=0/0", rf_w_addr, rf_w_data);
    end
    checks++;
    if (busy_mask !== 16'd0 || sb_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_sb got=%h/%b required=0/0", busy_mask, sb_err);
    end
    @(negedge clk);
    idle();
    rst = 1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    idle();
    issue_valid = 1; issue_addr = 3;
    #1;
    checks++;
    if (lo_ready !== 1'b1) begin
      failures++; $display("FAIL basic_ready got=%b required=1", lo_ready);
    end
    send_lo(3, 16'h1234, 0, 0);
    #1;
    checks++;
    if (rf_reg_we !== 1'b0) begin
      failures++; $display("FAIL basic_bypass got=%b required=0", rf_reg_we);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (busy_mask !== 16'h0008) begin
      failures++; $display("FAIL basic_busy got=%h required=0008", busy_mask);
    end
    checks++;
    if (rf_reg_we !== 1'b1 || rf_w_addr !== 4'd3) begin
      failures++;
      $display("FAIL basic_write got=%b/%0d required=1/3", rf_reg_we, rf_w_addr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy_mask !== 16'h0000 || rf_reg_we !== 1'b0) begin
      failures++;
      $display("FAIL basic_clear got=%h/%b required=0000/0", busy_mask, rf_reg_we);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] la [5] = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd8};
    int sent = 0;
    int n;
    bit exp_rdy;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle();
      wb_we = 1; wb_addr = 7; wb_data = 16'(16'h0F00 + c);
      if (c < 5) begin
        issue_valid = 1; issue_addr = la[c];
      end
      exp_rdy = (mcount < DEPTH);
      #1;
      checks++;
      if (lo_ready !== exp_rdy) begin
        failures++;
        $display("FAIL bp_ready cyc=%0d got=%b required=%b", c, lo_ready, exp_rdy);
      end
      checks++;
      if (rf_reg_we !== 1'b1 || rf_w_addr !== 4'd7
          || rf_w_data !== 16'(16'h0F00 + c)) begin
        failures++;
        $display("FAIL bp_wb cyc=%0d got=%b/%0d/%h required=1/7/%h",
                 c, rf_reg_we, rf_w_addr, rf_w_data, 16'(16'h0F00 + c));
      end
      if (sent < 5) begin
        send_lo(la[sent], 16'(16'hB000 + sent), 0, 0);
        if (exp_rdy) sent++;
      end
    end
    n = 0;
    while ((sent < 5 || sbq.size() > 0) && n < 20) begin
      @(negedge clk);
      idle();
      exp_rdy = (mcount < DEPTH);
      #1;
      checks++;
      if (lo_ready !== exp_rdy) begin
        failures++;
        $display("FAIL bp_drain_ready n=%0d got=%b required=%b", n, lo_ready, exp_rdy);
      end
      if (sent < 5) begin
        send_lo(la[sent], 16'(16'hB000 + sent), 0, 0);
        if (exp_rdy) sent++;
      end
      n++;
    end
    @(negedge clk);
    idle();
    #3;
    checks++;
    if (sbq.size() != 0 || sent != 5) begin
      failures++;
      $display("FAIL bp_timeout pending=%0d sent=%0d required=0/5", sbq.size(), sent);
    end
    checks++;
    if (busy_mask !== 16'd0 || sb_err !== 1'b0) begin
      failures++;
      $display("FAIL bp_sb got=%h/%b required=0000/0", busy_mask, sb_err);
    end
  endtask

  task automatic test_r15_hold();
    @(negedge clk);
    idle();
    issue_valid = 1; issue_addr = 9; issue_r15 = 1;
    send_lo(9, 16'hA9A9, 1, 16'h1515);
    @(negedge clk);
    idle();
    wb_r15_we = 1; wb_r15_data = 16'h7777;
    #1;
    checks++;
    if (rf_reg_we !== 1'b0 || rf_r15_we !== 1'b1 || rf_w_r15 !== 16'h7777) begin
      failures++;
      $display("FAIL r15_hold got=%b/%b/%h required=0/1/7777",
               rf_reg_we, rf_r15_we, rf_w_r15);
    end
    checks++;
    if (busy_mask !== 16'h8200) begin
      failures++; $display("FAIL r15_busy got=%h required=8200", busy_mask);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (rf_reg_we !== 1'b1 || rf_r15_we !== 1'b1 || rf_w_r15 !== 16'h1515) begin
      failures++;
      $display("FAIL r15_drain got=%b/%b/%h required=1/1/1515",
               rf_reg_we, rf_r15_we, rf_w_r15);
    end
    @(negedge clk);
    issue_valid = 1; issue_addr = 15;
    send_lo(15, 16'hF0F0, 0, 0);
    #1;
    checks++;
    if (busy_mask !== 16'h0000) begin
      failures++; $display("FAIL r15_clear got=%h required=0000", busy_mask);
    end
    @(negedge clk);
    idle();
    wb_r15_we = 1; wb_r15_data = 16'h1111;
    #1;
    checks++;
    if (rf_reg_we !== 1'b0 || rf_w_r15 !== 16'h1111) begin
      failures++;
      $display("FAIL r15_addr15_hold got=%b/%h required=0/1111", rf_reg_we, rf_w_r15);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (rf_reg_we !== 1'b1 || rf_w_addr !== 4'd15 || rf_r15_we !== 1'b0) begin
      failures++;
      $display("FAIL r15_addr15_drain got=%b/%0d/%b required=1/15/0",
               rf_reg_we, rf_w_addr, rf_r15_we);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy_mask !== 16'h0000) begin
      failures++; $display("FAIL r15_final got=%h required=0000", busy_mask);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle(); issue_valid = 1; issue_addr = 5;
    @(negedge clk);
    idle(); issue_valid = 1; issue_addr = 5;
    #1;
    checks++;
    if (busy_mask !== 16'h0020) begin
      failures++; $display("FAIL sb_busy1 got=%h required=0020", busy_mask);
    end
    @(negedge clk);
    idle(); send_lo(5, 16'h5001, 0, 0);
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    checks++;
    if (busy_mask !== 16'h0020 || sb_err !== 1'b0) begin
      failures++;
      $display("FAIL sb_one_left got=%h/%b required=0020/0", busy_mask, sb_err);
    end
    @(negedge clk);
    idle(); send_lo(5, 16'h5002, 0, 0);
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    checks++;
    if (busy_mask !== 16'h0000 || sb_err !== 1'b0) begin
      failures++;
      $display("FAIL sb_zero got=%h/%b required=0000/0", busy_mask, sb_err);
    end
    @(negedge clk);
    idle(); send_lo(5, 16'h5003, 0, 0);
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    checks++;
    if (sb_err !== 1'b1 || busy_mask !== 16'h0000) begin
      failures++;
      $display("FAIL sb_underflow got=%b/%h required=1/0000", sb_err, busy_mask);
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb_err !== 1'b1) begin
      failures++; $display("FAIL sb_sticky got=%b required=1", sb_err);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      wb_we = 1; wb_addr = 0; wb_data = 16'h0D0D;
      issue_valid = 1; issue_addr = 4'(i + 1);
      send_lo(4'(i + 1), 16'(16'hC000 + i), 0, 0);
    end
    @(negedge clk);
    idle();
    wb_we = 1;
    #1;
    checks++;
    if (busy_mask !== 16'h000E || lo_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre got=%h/%b required=000e/1", busy_mask, lo_ready);
    end
    @(negedge clk);
    idle();
    rst = 0;
    sbq.delete();
    mcount = 0;
    #1;
    checks++;
    if (lo_ready !== 1'b0 || busy_mask !== 16'd0 || sb_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got=%b/%h/%b required=0/0000/0",
               lo_ready, busy_mask, sb_err);
    end
    @(negedge clk);
    rst = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rf_reg_we !== 1'b0 || busy_mask !== 16'd0 || lo_ready !== 1'b1) begin
        failures++;
        $display("FAIL mid_after cyc=%0d got=%b/%h/%b required=0/0000/1",
                 c, rf_reg_we, busy_mask, lo_ready);
      end
    end
  endtask

`ifdef REG_WRITE_CTRL_FWD_EN
  task automatic test_fwd();
    @(negedge clk);
    idle();
    wb_we = 1; wb_addr = 15; wb_data = 16'hAAAA;
    wb_r15_we = 1; wb_r15_data = 16'h5555; fwd_addr = 15;
    #1;
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== 16'h5555) begin
      failures++;
      $display("FAIL fwd_r15 got=%b/%h required=1/5555", fwd_hit, fwd_data);
    end
    wb_r15_we = 0;
    #1;
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== 16'hAAAA) begin
      failures++;
      $display("FAIL fwd_gen got=%b/%h required=1/aaaa", fwd_hit, fwd_data);
    end
    fwd_addr = 3;
    #1;
    checks++;
    if (fwd_hit !== 1'b0 || fwd_data !== 16'h0000) begin
      failures++;
      $display("FAIL fwd_miss got=%b/%h required=0/0000", fwd_hit, fwd_data);
    end
    @(negedge clk);
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_r15_hold();
    test_scoreboard();
    test_reset_mid();
`ifdef REG_WRITE_CTRL_FWD_EN
    test_fwd();
`endif
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_ctrl.md
# reg_write_ctrl

Write-side controller for the 16x16 register file, sitting between the pipeline writeback stage, the long-latency (multiply/divide) unit and the register file's two write ports (general port plus dedicated R15 port). It merges single-cycle writebacks with buffered long-latency results without dropping either. It keeps a per-register scoreboard of outstanding long-latency destinations so hazard logic can stall dependent instructions.

## Interface
Parameters:
- DEPTH, 4, long-latency result queue entries (power of 2, 2..16)
- CW, 3, width of each scoreboard counter (must hold DEPTH)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- wb_we  in  1  pipeline writeback to general port this cycle
- wb_addr  in  4  pipeline destination register
- wb_data  in  16  pipeline write data
- wb_r15_we  in  1  pipeline side-write of R15 this cycle
- wb_r15_data  in  16  pipeline R15 data
- lo_valid  in  1  long-latency result offered
- lo_ready  out  1  queue can accept a result
- lo_addr  in  4  long-latency destination register
- lo_data  in  16  long-latency general-port data
- lo_r15  in  1  result also writes R15
- lo_r15_data  in  16  long-latency R15 data
- issue_valid  in  1  long-latency op issued this cycle
- issue_addr  in  4  its destination
- issue_r15  in  1  it will also write R15
- rf_w_addr  out  4  to register file W_addr
- rf_w_data  out  16  to register file W_data
- rf_reg_we  out  1  to register file reg_WE
- rf_w_r15  out  16  to register file W_R15
- rf_r15_we  out  1  to register file R15_WE
- busy_mask  out  16  bit i set while register i has outstanding long-latency writes
- sb_err  out  1  sticky: issue to saturated counter or drain of zero counter

## Operation
- Queue: FIFO of {addr, data, r15, r15_data}. Enqueue on lo_valid && lo_ready; lo_ready = !full, forced 0 while rst low. No enqueue-to-drain bypass; an accepted result is at the head no earlier than the next cycle.
- Write muxing (combinational): pipeline always owns the ports it asserts, never stalled. Head drains in a cycle only if wb_we=0 and (head.r15=0 or wb_r15_we=0) and not (wb_r15_we=1 and head.addr=15). On drain: rf_reg_we=1, rf_w_addr/data=head; if head.r15, rf_r15_we=1, rf_w_r15=head.r15_data.
- Otherwise rf_* mirror wb_* directly. Unused data/addr outputs drive 0.
- Full and drain in the same cycle: lo_ready still 0 that cycle.
- Scoreboard: 16 counters of CW bits. Issue increments cnt[issue_addr], plus cnt[15] if issue_r15 and issue_addr!=15. Drain decrements identically from head fields. Same-cycle increment and decrement of one counter: net no change. busy_mask[i] = cnt[i]!=0.
- Increment at max or decrement at 0: counter unchanged, sb_err set until reset.
- Reset (async, rst low): queue empty, all counters 0, sb_err=0, rf_reg_we=rf_r15_we=0, rf_* data/addr=0, busy_mask=0.

## Timing
- Pipeline write: zero latency, rf_* valid same cycle, landed in register file at next edge.
- Long-latency result accepted at edge k: earliest rf write at edge k+1; busy bit clears after edge k+1.
- Drain order strictly FIFO; a blocked head blocks all later entries.
- Reset asserted mid-operation discards queued results and scoreboard state immediately.

## Configuration
- REG_WRITE_CTRL_FWD_EN defined: adds ports fwd_addr (in 4), fwd_hit (out 1), fwd_data (out 16). Hit when fwd_addr matches the general-port write driven this cycle (data = rf_w_data) or, for fwd_addr=15, an active R15-port write (data = rf_w_r15; R15 port wins over general port, matching register file write order). Combinational, 0 during reset.
- Not defined: ports absent, no forwarding logic.

## Test plan
- Reset release, lo_valid=1 addr 3 data 16'h1234, no pipeline writes -> rf_reg_we=1 addr 3 data 16'h1234 one cycle after acceptance; busy_mask[3] cleared after the issue+drain pair.
- wb_we=1 held for 6 cycles with 5 lo results (DEPTH=4) -> lo_ready drops after 4th accept; queue drains in order after wb_we falls.
- Head with lo_r15=1 while wb_r15_we=1 -> head holds; drains next cycle with rf_r15_we=1 and head r15 data.
- Issue to addr 5 twice, drain one -> busy_mask[5] stays 1; drain second -> 0; extra drain sets sb_err.
- Assert rst with 3 queued entries -> lo_ready=0, busy_mask=0, no rf write after release.
- With FWD_EN: wb_we=1 addr 15 data 16'hAAAA plus wb_r15_we=1 data 16'h5555, fwd_addr=15 -> fwd_hit=1, fwd_data=16'h5555.
